// File: rtl/mac_accum_drain_pkg.sv
// Shared types and width helpers for the saturating multiply-accumulate drain block.
package mac_accum_drain_pkg;

  typedef enum logic [1:0] {
    MAD_IDLE,
    MAD_ACCUM,
    MAD_HOLD
  } mad_state_e;

  function automatic int acc_width(input int len, input int guard);
    return 2 * len + guard;
  endfunction

  // Two's complement bounds for a w-bit signed value, returned in 64 bits for slicing.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/mac_accum_drain_sat_narrow.sv
// Narrows a wide signed accumulator: arithmetic shift by FRAC (floor), then clip to LEN bits.
module mac_accum_drain_sat_narrow
  import mac_accum_drain_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int ACC_W = 20,
  parameter int FRAC  = 0
) (
  input  logic [ACC_W-1:0] sum_i,
  output logic [LEN-1:0]   data_o,
  output logic             clipped_o
);

  localparam logic signed [63:0]      OUT_MAX64 = sat_max(LEN);
  localparam logic signed [63:0]      OUT_MIN64 = sat_min(LEN);
  localparam logic signed [ACC_W-1:0] OUT_MAX   = OUT_MAX64[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0] OUT_MIN   = OUT_MIN64[ACC_W-1:0];

  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] shifted;

  assign sum_s   = sum_i;
  assign shifted = sum_s >>> FRAC;

  always_comb begin
    data_o    = shifted[LEN-1:0];
    clipped_o = 1'b0;
    if (shifted > OUT_MAX) begin
      data_o    = OUT_MAX[LEN-1:0];
      clipped_o = 1'b1;
    end else if (shifted < OUT_MIN) begin
      data_o    = OUT_MIN[LEN-1:0];
      clipped_o = 1'b1;
    end
  end

endmodule

// File: rtl/mac_accum_drain.sv
// Streams signed operand pairs into a saturating wide dot product, then holds the
// narrowed LEN-bit result until the write-back side takes it.
module mac_accum_drain
  import mac_accum_drain_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int GUARD = 4,
  parameter int FRAC  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN-1:0]   in_a,
  input  logic [LEN-1:0]   in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN-1:0]   out_data,
  output logic             out_sat,
  output logic [GUARD:0]   out_terms
);

  localparam int ACC_W  = acc_width(LEN, GUARD);
  localparam int TERM_W = GUARD + 1;
  localparam logic signed [63:0]      ACC_MAX64 = sat_max(ACC_W);
  localparam logic signed [63:0]      ACC_MIN64 = sat_min(ACC_W);
  localparam logic signed [ACC_W-1:0] ACC_MAX   = ACC_MAX64[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0] ACC_MIN   = ACC_MIN64[ACC_W-1:0];

  mad_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_acc_q, sat_acc_d;
  logic [LEN-1:0]          data_q, data_d;
  logic                    out_sat_q, out_sat_d;
  logic [TERM_W-1:0]       terms_q, terms_d;

  logic signed [LEN-1:0]   a_s, b_s;
  logic signed [2*LEN-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext, acc_base, sum_raw, sum_sat;
  logic                    first_beat, ovf, sat_new;
  logic [TERM_W-1:0]       terms_new;
  logic [LEN-1:0]          narrow_data;
  logic                    narrow_clipped;

  assign a_s      = in_a;
  assign b_s      = in_b;
  assign prod     = a_s * b_s;
  assign prod_ext = prod;

  assign first_beat = (state_q == MAD_IDLE);
  assign acc_base   = first_beat ? '0 : acc_q;
  assign sum_raw    = acc_base + prod_ext;
  // Overflow only when both addends share a sign and the wrapped sum does not.
  assign ovf        = (acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_raw[ACC_W-1] != acc_base[ACC_W-1]);
  assign sum_sat    = ovf ? (acc_base[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
  assign sat_new    = (first_beat ? 1'b0 : sat_acc_q) | ovf;
  assign terms_new  = first_beat ? TERM_W'(1) :
                      (&terms_q) ? terms_q : terms_q + TERM_W'(1);

  mac_accum_drain_sat_narrow #(
    .LEN   (LEN),
    .ACC_W (ACC_W),
    .FRAC  (FRAC)
  ) u_sat_narrow (
    .sum_i     (sum_sat),
    .data_o    (narrow_data),
    .clipped_o (narrow_clipped)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sat_acc_d = sat_acc_q;
    data_d    = data_q;
    out_sat_d = out_sat_q;
    terms_d   = terms_q;
    case (state_q)
      MAD_IDLE, MAD_ACCUM: begin
        if (in_valid) begin
          acc_d     = sum_sat;
          sat_acc_d = sat_new;
          terms_d   = terms_new;
          if (in_last) begin
            state_d   = MAD_HOLD;
            data_d    = narrow_data;
            out_sat_d = narrow_clipped | sat_new;
          end else begin
            state_d = MAD_ACCUM;
          end
        end
      end
      MAD_HOLD: begin
        if (out_ready) begin
          state_d = MAD_IDLE;
        end
      end
      default: state_d = MAD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MAD_IDLE;
      acc_q     <= '0;
      sat_acc_q <= 1'b0;
      data_q    <= '0;
      out_sat_q <= 1'b0;
      terms_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sat_acc_q <= sat_acc_d;
      data_q    <= data_d;
      out_sat_q <= out_sat_d;
      terms_q   <= terms_d;
    end
  end

  assign in_ready  = (state_q != MAD_HOLD);
  assign out_valid = (state_q == MAD_HOLD);
  assign out_data  = data_q;
  assign out_sat   = out_sat_q;
  assign out_terms = terms_q;

endmodule

// File: tb/tb_mac_accum_drain.sv
// Directed bench: two instances (FRAC=0 and FRAC=4) share one stimulus stream.
module tb_mac_accum_drain;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_last, out_ready;
  logic [7:0] in_a, in_b;

  logic       rdy0, vld0, sat0;
  logic [7:0] data0;
  logic [4:0] terms0;
  logic       rdy1, vld1, sat1;
  logic [7:0] data1;
  logic [4:0] terms1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_accum_drain #(.LEN(8), .GUARD(4), .FRAC(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(vld0),
    .out_ready(out_ready), .out_data(data0), .out_sat(sat0), .out_terms(terms0)
  );

  mac_accum_drain #(.LEN(8), .GUARD(4), .FRAC(4)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(vld1),
    .out_ready(out_ready), .out_data(data1), .out_sat(sat1), .out_terms(terms1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    check("in_ready_before_beat", rdy0, 1'b1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take(input string tag, input logic [7:0] d0, input logic s0,
                      input logic [7:0] d1, input logic s1, input logic [4:0] t);
    check({tag, "_valid"}, vld0, 1'b1);
    check({tag, "_data0"}, data0, d0);
    check({tag, "_sat0"}, sat0, s0);
    check({tag, "_terms"}, terms0, t);
    check({tag, "_data1"}, data1, d1);
    check({tag, "_sat1"}, sat1, s1);
    $display("result %s: data0=%h sat0=%b data1=%h sat1=%b terms=%0d",
             tag, data0, sat0, data1, sat1, terms0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drained"}, vld0, 1'b0);
    check({tag, "_ready_after"}, rdy0, 1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    in_a      = 8'd5;
    in_b      = 8'd5;
    out_ready = 1'b0;

    // Reset held three cycles with a beat offered: nothing may be accepted.
    repeat (3) tick();
    check("rst_valid", vld0, 1'b0);
    check("rst_data", data0, 8'h00);
    check("rst_terms", terms0, 5'd0);
    check("rst_sat", sat0, 1'b0);
    reset    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("rst_ready", rdy0, 1'b1);
    tick();
    check("rst_no_output", vld0, 1'b0);

    // Single beat 3 * -4 = -12.
    beat(8'd3, -8'sd4, 1'b1);
    take("single", 8'hF4, 1'b0, 8'hFF, 1'b0, 5'd1);

    // Positive clip: 3 * 100 = 300.
    beat(8'd10, 8'd10, 1'b0);
    beat(8'd10, 8'd10, 1'b0);
    beat(8'd10, 8'd10, 1'b1);
    take("clip_pos", 8'h7F, 1'b1, 8'h12, 1'b0, 5'd3);

    // Negative clip: 2 * -16256 = -32512.
    beat(-8'sd128, 8'd127, 1'b0);
    beat(-8'sd128, 8'd127, 1'b1);
    take("clip_neg", 8'h80, 1'b1, 8'h80, 1'b1, 5'd2);

    // Backpressure: result stays put while in_valid is offered.
    beat(8'd1, 8'd2, 1'b1);
    in_valid = 1'b1;
    in_a     = 8'd7;
    in_b     = 8'd7;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ready", rdy0, 1'b0);
      check("bp_valid", vld0, 1'b1);
      check("bp_data", data0, 8'h02);
      check("bp_terms", terms0, 5'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_drain_valid", vld0, 1'b0);
    check("bp_drain_ready", rdy0, 1'b1);
    $display("result backpressure: drained data=02 while input offered");
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    take("bp_next", 8'h31, 1'b0, 8'h03, 1'b0, 5'd1);

    // Fixed point on the FRAC=4 instance: 2.0 * 1.5 = 3.0.
    beat(8'h20, 8'h18, 1'b1);
    take("frac_mul", 8'h7F, 1'b1, 8'h30, 1'b0, 5'd1);
    beat(-8'sd1, 8'd1, 1'b1);
    take("frac_floor", 8'hFF, 1'b0, 8'hFF, 1'b0, 5'd1);

    // 20 * 16384 = 327680: clipped on output but within the accumulator.
    for (int i = 0; i < 20; i++) beat(-8'sd128, -8'sd128, (i == 19));
    take("big20", 8'h7F, 1'b1, 8'h7F, 1'b1, 5'd20);

    // Accumulator pins at 524287 on beat 32, then is walked back to -1.
    // An unsaturated sum would end at 0, so data=-1 proves the clamp.
    for (int i = 0; i < 32; i++) beat(-8'sd128, -8'sd128, 1'b0);
    for (int i = 0; i < 32; i++) beat(-8'sd128, 8'd127, 1'b0);
    beat(-8'sd64, 8'd64, 1'b1);
    take("acc_sat", 8'hFF, 1'b1, 8'hFF, 1'b1, 5'd31);

    // Reset mid-stream discards the partial sum.
    beat(8'd100, 8'd100, 1'b0);
    beat(8'd100, 8'd100, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", vld0, 1'b0);
    check("midrst_ready", rdy0, 1'b1);
    tick();
    check("midrst_no_output", vld0, 1'b0);
    beat(8'd3, -8'sd4, 1'b1);
    take("after_rst", 8'hF4, 1'b0, 8'hFF, 1'b0, 5'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
